// File: rtl/bsg_clk_gen_pearl_pkg.sv
// bsg_clk_gen_pearl_pkg: shared state type and saturation helper for the pearl frequency monitor
package bsg_clk_gen_pearl_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} bsg_clk_gen_pearl_mon_state_e;
  localparam int unsigned sat_width_max_lp = 32;
  function automatic logic [sat_width_max_lp-1:0] sat_val(input int unsigned width);
    return sat_width_max_lp'((64'd1 << width) - 64'd1);
  endfunction
endpackage

// File: rtl/bsg_clk_gen_pearl_edge_counter.sv
// bsg_clk_gen_pearl_edge_counter: per-channel toggle edge detect and saturating edge counter
module bsg_clk_gen_pearl_edge_counter
  import bsg_clk_gen_pearl_pkg::*;
#(parameter int count_width_p = 12)
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     toggle_i,
  input  logic                     clear_i,
  input  logic                     count_en_i,
  output logic [count_width_p-1:0] count_next_o
);
  localparam logic [count_width_p-1:0] sat_lp = count_width_p'(sat_val(count_width_p));
  logic toggle_q, edge_l;
  logic [count_width_p-1:0] count_q, count_d;
  assign edge_l = toggle_i != toggle_q;
  // next value is exported so the final window cycle's edge lands in the report
  assign count_d = clear_i ? '0
                 : (count_en_i && edge_l && count_q != sat_lp) ? count_q + count_width_p'(1)
                 : count_q;
  assign count_next_o = count_d;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      toggle_q <= 1'b0;
      count_q  <= '0;
    end else begin
      toggle_q <= toggle_i;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bsg_clk_gen_pearl_freq_monitor.sv
// bsg_clk_gen_pearl_freq_monitor: windowed multi-channel edge counting with bound check and sticky errors
module bsg_clk_gen_pearl_freq_monitor
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int num_clk_p      = 4,
  parameter int window_width_p = 16,
  parameter int count_width_p  = 12
)
(
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               en_i,
  input  logic [window_width_p-1:0]          window_cycles_i,
  input  logic [num_clk_p-1:0]               toggle_i,
  input  logic [num_clk_p*count_width_p-1:0] min_count_i,
  input  logic [num_clk_p*count_width_p-1:0] max_count_i,
  input  logic                               clear_i,
  output logic [num_clk_p*count_width_p-1:0] count_o,
  output logic                               count_v_o,
  output logic [num_clk_p-1:0]               pass_o,
  output logic [num_clk_p-1:0]               error_o
);
  bsg_clk_gen_pearl_mon_state_e state_q, state_d;
  logic [window_width_p-1:0] win_q, win_d;
  logic [num_clk_p*count_width_p-1:0] cnt_next, count_q;
  logic [num_clk_p-1:0] pass_d, pass_q, error_q;
  logic count_v_q, start, clr, cnt_en, fin;
  assign start = en_i && (window_cycles_i != '0);
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      MEASURE: begin
        if (!en_i) state_d = IDLE;
        else begin
          cnt_en  = 1'b1;
          fin     = win_q == '0;
          state_d = fin ? REPORT : MEASURE;
          win_d   = fin ? win_q : win_q - window_width_p'(1);
        end
      end
      default: begin
        clr     = start;
        state_d = start ? MEASURE : IDLE;
        win_d   = start ? window_cycles_i - window_width_p'(1) : win_q;
      end
    endcase
  end
  for (genvar i = 0; i < num_clk_p; i++) begin : ch
    bsg_clk_gen_pearl_edge_counter #(.count_width_p(count_width_p)) ctr (
      .clk_i,
      .reset_i,
      .toggle_i(toggle_i[i]),
      .clear_i(clr),
      .count_en_i(cnt_en),
      .count_next_o(cnt_next[i*count_width_p +: count_width_p])
    );
  end
  // an inverted bound range (min > max) can never be satisfied, so it fails naturally
  always_comb begin
    pass_d = '0;
    for (int i = 0; i < num_clk_p; i++)
      pass_d[i] = (min_count_i[i*count_width_p +: count_width_p] <= cnt_next[i*count_width_p +: count_width_p])
               && (cnt_next[i*count_width_p +: count_width_p] <= max_count_i[i*count_width_p +: count_width_p]);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      win_q     <= '0;
      count_q   <= '0;
      pass_q    <= '0;
      error_q   <= '0;
      count_v_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      count_v_q <= fin;
      count_q   <= fin ? cnt_next : count_q;
      pass_q    <= fin ? pass_d : pass_q;
      error_q   <= (clear_i ? '0 : error_q) | (fin ? ~pass_d : '0);
    end
  end
  assign count_o   = count_q;
  assign count_v_o = count_v_q;
  assign pass_o    = pass_q;
  assign error_o   = error_q;
endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_monitor.sv
// tb_bsg_clk_gen_pearl_freq_monitor: directed plus randomized windows against an edge-counting reference model
module tb_bsg_clk_gen_pearl_freq_monitor;
  logic clk = 1'b0;
  logic reset_i = 1'b1, en_i = 1'b0, clear_i = 1'b0;
  logic [15:0] window_cycles_i = '0;
  logic [3:0] toggle_i = '0;
  logic [47:0] min_count_i = '0, max_count_i = '0;
  logic [47:0] count_o;
  logic count_v_o;
  logic [3:0] pass_o, error_o;
  logic [15:0] count_s;
  logic v_s;
  logic [3:0] pass_s, err_s;
  int checks = 0, failures = 0, cyc = 0;
  int mn[4], mx[4], ec[4], es[4];
  logic [3:0] ep = '0, err_m = '0, prev = '0;

  always #5 clk = ~clk;

  bsg_clk_gen_pearl_freq_monitor dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .window_cycles_i(window_cycles_i),
    .toggle_i(toggle_i), .min_count_i(min_count_i), .max_count_i(max_count_i), .clear_i(clear_i),
    .count_o(count_o), .count_v_o(count_v_o), .pass_o(pass_o), .error_o(error_o));

  bsg_clk_gen_pearl_freq_monitor #(.count_width_p(4)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .window_cycles_i(window_cycles_i),
    .toggle_i(toggle_i), .min_count_i(16'h0), .max_count_i(16'hFFFF), .clear_i(clear_i),
    .count_o(count_s), .count_v_o(v_s), .pass_o(pass_s), .error_o(err_s));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pack12();
    logic [47:0] r = '0;
    for (int c = 0; c < 4; c++) r[c*12 +: 12] = 12'(ec[c]);
    return r;
  endfunction

  function automatic logic [15:0] pack4();
    logic [15:0] r = '0;
    for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(es[c]);
    return r;
  endfunction

  task automatic tick();
    prev = reset_i ? 4'b0 : toggle_i;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gen_tog(input bit rnd);
    toggle_i = rnd ? 4'($urandom) : {cyc[2], 1'b0, cyc[1], cyc[0]};
  endtask

  task automatic set_bounds(input int c, input int lo, input int hi);
    mn[c] = lo;
    mx[c] = hi;
    min_count_i[c*12 +: 12] = 12'(lo);
    max_count_i[c*12 +: 12] = 12'(hi);
  endtask

  task automatic open_bounds();
    for (int c = 0; c < 4; c++) set_bounds(c, 0, 4095);
  endtask

  task automatic run_window(input int w, input bit rnd, input bit clr_last);
    int cnt[4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    en_i = 1'b1;
    window_cycles_i = 16'(w);
    gen_tog(rnd);
    tick();
    for (int k = 1; k <= w; k++) begin
      check("v_low_in_window", 64'(count_v_o), 64'd0);
      gen_tog(rnd);
      clear_i = clr_last && (k == w);
      for (int c = 0; c < 4; c++) if (toggle_i[c] != prev[c]) cnt[c]++;
      tick();
    end
    clear_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ec[c] = cnt[c] > 4095 ? 4095 : cnt[c];
      es[c] = cnt[c] > 15 ? 15 : cnt[c];
      ep[c] = (mn[c] <= ec[c]) && (ec[c] <= mx[c]);
    end
    err_m = (clr_last ? 4'b0 : err_m) | ~ep;
    check("count_v_pulse", 64'(count_v_o), 64'd1);
    check("count", 64'(count_o), 64'(pack12()));
    check("pass", 64'(pass_o), 64'(ep));
    check("error", 64'(error_o), 64'(err_m));
    check("count_sat4", 64'(count_s), 64'(pack4()));
  endtask

  task automatic partial(input int w, input int n);
    en_i = 1'b1;
    window_cycles_i = 16'(w);
    gen_tog(1);
    tick();
    repeat (n) begin
      check("v_low_partial", 64'(count_v_o), 64'd0);
      gen_tog(1);
      tick();
    end
  endtask

  task automatic go_idle();
    en_i = 1'b0;
    tick();
    check("v_low_idle", 64'(count_v_o), 64'd0);
    check("count_hold", 64'(count_o), 64'(pack12()));
    check("pass_hold", 64'(pass_o), 64'(ep));
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin ec[c] = 0; es[c] = 0; end
    open_bounds();
    tick();
    tick();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_v", 64'(count_v_o), 64'd0);
    check("rst_pass", 64'(pass_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    reset_i = 1'b0;
    run_window(8, 0, 0);
    go_idle();
    set_bounds(0, 8, 8);
    set_bounds(1, 5, 9);
    set_bounds(2, 0, 0);
    set_bounds(3, 3, 1);
    run_window(8, 0, 0);
    set_bounds(1, 4, 4);
    run_window(8, 0, 0);
    go_idle();
    open_bounds();
    run_window(32, 0, 0);
    go_idle();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    err_m = '0;
    check("clear_idle", 64'(error_o), 64'(err_m));
    set_bounds(0, 100, 100);
    set_bounds(1, 100, 100);
    run_window(8, 0, 0);
    open_bounds();
    set_bounds(2, 1, 1);
    run_window(8, 0, 1);
    go_idle();
    open_bounds();
    partial(16, 2);
    en_i = 1'b0;
    gen_tog(1);
    tick();
    repeat (20) begin
      check("v_low_abort", 64'(count_v_o), 64'd0);
      gen_tog(1);
      tick();
    end
    check("count_hold_abort", 64'(count_o), 64'(pack12()));
    run_window(16, 1, 0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) set_bounds(c, $urandom_range(0, 12), $urandom_range(0, 40));
      run_window($urandom_range(1, 40), 1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
    en_i = 1'b1;
    window_cycles_i = '0;
    repeat (5) begin
      tick();
      check("v_low_w0", 64'(count_v_o), 64'd0);
    end
    check("count_hold_w0", 64'(count_o), 64'(pack12()));
    partial(10, 4);
    reset_i = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin ec[c] = 0; es[c] = 0; end
    ep = '0;
    err_m = '0;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_v", 64'(count_v_o), 64'd0);
    check("midrst_pass", 64'(pass_o), 64'd0);
    check("midrst_error", 64'(error_o), 64'd0);
    en_i = 1'b0;
    reset_i = 1'b0;
    tick();
    run_window(5, 1, 0);
    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
